// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller.
// Holds the FSM state encoding and the settle counter width.
package gate_sweep_pkg;

    // Settle counter width; covers SETTLE_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate_sweep_ctrl_settle_counter.sv
// Loadable down-counter that times how long each input combination is held.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load_i     : load LOAD_VAL (takes priority over dec_i)
//   dec_i      : decrement by one, saturating at zero
//   zero_c     : combinational flag, counter currently reads zero
module settle_counter
    import gate_sweep_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 1
)(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input combination of a small N_IN-input logic unit in
// ascending order, holds each for SETTLE_CYCLES, samples the unit output
// into a truth table and compares it against an expected table.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start        : begin a sweep (accepted in IDLE only)
//   abort        : end a sweep in progress, no done pulse
//   expected     : expected truth table, latched on start
//   dut_c        : output of the unit under control
//   dut_in       : drives the unit inputs (current row)
//   busy         : sweep in progress
//   done         : one-cycle completion pulse
//   table_out    : captured truth table
//   mismatch     : sticky, some row differed from expected
//   fail_row     : first mismatching row, 0 if none
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 2
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(2**N_IN)-1:0]   expected,
    input  logic                   dut_c,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic                   mismatch,
    output logic [N_IN-1:0]        fail_row
);

    localparam int unsigned ROWS = 2**N_IN;

    state_e            state_q,    state_d;
    logic [N_IN-1:0]   row_q,      row_d;
    logic [ROWS-1:0]   exp_q,      exp_d;
    logic [ROWS-1:0]   table_q,    table_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              mismatch_q, mismatch_d;
    logic [N_IN-1:0]   fail_row_q, fail_row_d;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero_c;

    settle_counter #(
        .LOAD_VAL (SETTLE_CYCLES - 1)
    ) u_settle_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_c (cnt_zero_c)
    );

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        exp_d      = exp_q;
        table_d    = table_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        fail_row_d = fail_row_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    exp_d      = expected;
                    row_d      = '0;
                    table_d    = '0;
                    mismatch_d = 1'b0;
                    fail_row_d = '0;
                    busy_d     = 1'b1;
                    cnt_load   = 1'b1;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_zero_c) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            SAMPLE: begin
                // abort suppresses this row's capture entirely.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    table_d[row_q] = dut_c;
                    if ((dut_c != exp_q[row_q]) && !mismatch_q) begin
                        mismatch_d = 1'b1;
                        fail_row_d = row_q;
                    end
                    if (row_q == N_IN'(ROWS - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = SETTLE;
                        row_d    = row_q + N_IN'(1);
                        cnt_load = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            fail_row_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            exp_q      <= exp_d;
            table_q    <= table_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            fail_row_q <= fail_row_d;
        end
    end

    // The row register drives the unit inputs directly.
    assign dut_in    = row_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign fail_row  = fail_row_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: instance A uses the defaults,
// instance B uses SETTLE_CYCLES=1. Labels: "edge k" is the value seen
// just before posedge k, where edge 0 is the edge that samples start.
module tb_gate_sweep_ctrl;

    localparam logic [1:0] G_AND  = 2'd0;
    localparam logic [1:0] G_XOR  = 2'd1;
    localparam logic [1:0] G_XNOR = 2'd2;
    localparam logic [1:0] G_NAND = 2'd3;

    typedef struct {
        logic [3:0] tbl;
        logic       mm;
        logic [1:0] frow;
        int         done_lbl;
        int         busy_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [3:0] exp_a = '0, exp_b = '0;
    logic [1:0] gate_a = '0, gate_b = '0;
    logic       dut_c_a, dut_c_b;

    logic [1:0] dut_in_a, dut_in_b, fr_a, fr_b;
    logic       busy_a, busy_b, done_a, done_b, mm_a, mm_b;
    logic [3:0] table_a, table_b;

    int   edge_n = 0;
    int   start_edge = 0;
    int   vectors = 0;
    int   errors = 0;
    int   busy_cnt_a = 0;
    int   busy_cnt_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic gate_f(input logic [1:0] sel, input logic [1:0] x);
        case (sel)
            G_AND:   return x[1] & x[0];
            G_XOR:   return x[1] ^ x[0];
            G_XNOR:  return ~(x[1] ^ x[0]);
            default: return ~(x[1] & x[0]);
        endcase
    endfunction

    assign dut_c_a = gate_f(gate_a, dut_in_a);
    assign dut_c_b = gate_f(gate_b, dut_in_b);

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected(exp_a), .dut_c(dut_c_a), .dut_in(dut_in_a), .busy(busy_a),
        .done(done_a), .table_out(table_a), .mismatch(mm_a), .fail_row(fr_a)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected(exp_b), .dut_c(dut_c_b), .dut_in(dut_in_b), .busy(busy_b),
        .done(done_b), .table_out(table_b), .mismatch(mm_b), .fail_row(fr_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_result(input string who, input exp_t e, input int lbl, input int bcnt,
                                input logic [3:0] tbl, input logic mm, input logic [1:0] fr);
        chk({who, "_table_out"}, 32'(tbl), 32'(e.tbl));
        chk({who, "_mismatch"},  32'(mm),  32'(e.mm));
        chk({who, "_fail_row"},  32'(fr),  32'(e.frow));
        chk({who, "_done_edge"}, 32'(lbl), 32'(e.done_lbl));
        chk({who, "_busy_cycles"}, 32'(bcnt), 32'(e.busy_cyc));
    endtask

    // Monitor A: per-cycle dut_in check while busy, scoreboard pop on done.
    always begin : mon_a
        int   lbl;
        exp_t e;
        @(negedge clk); #1;
        lbl = edge_n - start_edge + 1;
        if (lbl == 0) busy_cnt_a = 0;
        if (busy_a) begin
            busy_cnt_a++;
            chk("a_dut_in", 32'(dut_in_a), 32'((lbl - 1) / 3));
        end
        if (done_a) begin
            if (q_a.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL a_spurious_done: done=1 at edge %0d, want no done", lbl);
            end else begin
                e = q_a.pop_front();
                check_result("a", e, lbl, busy_cnt_a, table_a, mm_a, fr_a);
            end
        end
    end

    // Monitor B: same checks for the SETTLE_CYCLES=1 instance.
    always begin : mon_b
        int   lbl;
        exp_t e;
        @(negedge clk); #1;
        lbl = edge_n - start_edge + 1;
        if (lbl == 0) busy_cnt_b = 0;
        if (busy_b) begin
            busy_cnt_b++;
            chk("b_dut_in", 32'(dut_in_b), 32'((lbl - 1) / 2));
        end
        if (done_b) begin
            if (q_b.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL b_spurious_done: done=1 at edge %0d, want no done", lbl);
            end else begin
                e = q_b.pop_front();
                check_result("b", e, lbl, busy_cnt_b, table_b, mm_b, fr_b);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge (edge 0).
    // Returns at the negedge right after edge 0.
    task automatic start_sweep(input bit use_b, input logic [1:0] g, input logic [3:0] e);
        start_edge = edge_n + 1;
        if (use_b) begin
            gate_b = g; exp_b = e; start_b = 1'b1;
        end else begin
            gate_a = g; exp_a = e; start_a = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Advance to the negedge following edge k of the current sweep.
    task automatic to_rel(input int k);
        while (edge_n - start_edge < k) @(negedge clk);
    endtask

    task automatic wait_drain_a();
        int n = 0;
        while (q_a.size() != 0 && n < 60) begin @(negedge clk); n++; end
        chk("a_done_seen", 32'(q_a.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain_b();
        int n = 0;
        while (q_b.size() != 0 && n < 60) begin @(negedge clk); n++; end
        chk("b_done_seen", 32'(q_b.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero_a(input string tag);
        chk({tag, "_dut_in"},    32'(dut_in_a), 32'd0);
        chk({tag, "_busy"},      32'(busy_a),   32'd0);
        chk({tag, "_done"},      32'(done_a),   32'd0);
        chk({tag, "_table_out"}, 32'(table_a),  32'd0);
        chk({tag, "_mismatch"},  32'(mm_a),     32'd0);
        chk({tag, "_fail_row"},  32'(fr_a),     32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero_a("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // AND unit, all rows match.
        q_a.push_back('{tbl: 4'b1000, mm: 1'b0, frow: 2'd0, done_lbl: 13, busy_cyc: 12});
        start_sweep(1'b0, G_AND, 4'b1000);
        wait_drain_a();

        // XOR unit against AND table: first failure is row 1.
        q_a.push_back('{tbl: 4'b0110, mm: 1'b1, frow: 2'd1, done_lbl: 13, busy_cyc: 12});
        start_sweep(1'b0, G_XOR, 4'b1000);
        wait_drain_a();

        // start re-asserted mid-sweep (edge 4) and in DONE (edge 13) is ignored.
        q_a.push_back('{tbl: 4'b1000, mm: 1'b0, frow: 2'd0, done_lbl: 13, busy_cyc: 12});
        start_sweep(1'b0, G_AND, 4'b1000);
        to_rel(3);  start_a = 1'b1;
        to_rel(4);  start_a = 1'b0;
        to_rel(12); start_a = 1'b1;
        to_rel(13); start_a = 1'b0;
        chk("restart_in_done_busy", 32'(busy_a), 32'd0);
        chk("restart_in_done_table", 32'(table_a), 32'h8);
        // start at edge 14 is accepted and clears the table.
        q_a.push_back('{tbl: 4'b1000, mm: 1'b0, frow: 2'd0, done_lbl: 13, busy_cyc: 12});
        start_sweep(1'b0, G_AND, 4'b1000);
        chk("restart_busy", 32'(busy_a), 32'd1);
        chk("restart_table_cleared", 32'(table_a), 32'd0);
        wait_drain_a();

        // abort sampled in SAMPLE of row 1: row 0 kept, row 1 not captured.
        start_sweep(1'b0, G_NAND, 4'b1000);
        to_rel(5); abort_a = 1'b1;
        to_rel(6); abort_a = 1'b0;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_table_out", 32'(table_a), 32'h1);
        chk("abort_mismatch", 32'(mm_a), 32'd1);
        chk("abort_fail_row", 32'(fr_a), 32'd0);
        chk("abort_dut_in", 32'(dut_in_a), 32'd1);
        repeat (20) @(negedge clk);
        chk("abort_idle_busy", 32'(busy_a), 32'd0);
        chk("abort_idle_table", 32'(table_a), 32'h1);
        chk("abort_idle_dut_in", 32'(dut_in_a), 32'd1);

        // Asynchronous reset during SETTLE of row 2.
        start_sweep(1'b0, G_XOR, 4'b0001);
        to_rel(7);
        chk("pre_reset_dut_in", 32'(dut_in_a), 32'd2);
        chk("pre_reset_table", 32'(table_a), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_all_zero_a("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_all_zero_a("post_reset_idle");

        // SETTLE_CYCLES=1 instance, XNOR unit matches.
        q_b.push_back('{tbl: 4'b1001, mm: 1'b0, frow: 2'd0, done_lbl: 9, busy_cyc: 8});
        start_sweep(1'b1, G_XNOR, 4'b1001);
        wait_drain_b();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer for a small combinational/registered logic unit with N_IN single-bit inputs and one output, such as the team's two-input gate workspace blocks. On `start` it drives every input combination in ascending order. After each combination it waits a programmable settle time, samples the unit's output into a truth-table register, and compares it against an expected table. It reports busy/done status and the first failing row, so gate blocks can be self-checked on hardware or in a top-level bench without hand-written stimulus.

## Interface
Parameters:
- N_IN, default 2: number of unit inputs; table width is 2**N_IN (legal range 1–4).
- SETTLE_CYCLES, default 2: number of cycles each combination is held before it is sampled (legal range 1–15).

Ports:
- clk, input, 1: the single clock; rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: begins a sweep when sampled high in IDLE; ignored otherwise.
- abort, input, 1: synchronous; ends a sweep in progress without asserting `done`.
- expected, input, 2**N_IN: expected output per row; bit r corresponds to input value r. Latched on start.
- dut_c, input, 1: output of the controlled unit.
- dut_in, output, N_IN: drives the unit's inputs; bit 0 is the LSB (unit input `a` when N_IN=2, `b` is bit 1).
- busy, output, 1: high from the cycle after start until the DONE cycle, exclusive.
- done, output, 1: one-cycle pulse at sweep completion.
- table_out, output, 2**N_IN: captured outputs; bit r holds the sample for row r.
- mismatch, output, 1: sticky; set if any sampled row differs from `expected`.
- fail_row, output, N_IN: index of the first mismatching row; 0 if there was none.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - With start=1, go to SETTLE. In the same transition: latch `expected`, set row=0, set dut_in=0, clear table_out, mismatch and fail_row, and load the settle counter with SETTLE_CYCLES-1.
- **SETTLE**
  - Hold dut_in=row.
  - Decrement the counter each cycle. Go to SAMPLE on the cycle the counter reads 0, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- **SAMPLE** (one cycle; dut_in still equals row)
  - Capture table_out[row] <= dut_c.
  - If dut_c != expected[row] and mismatch=0, set mismatch=1 and fail_row=row.
  - If row = 2**N_IN-1, go to DONE. Otherwise increment row, drive the new row on dut_in, reload the counter, and go to SETTLE.
- **DONE**
  - Assert done=1 for one cycle, then go to IDLE.
  - dut_in, table_out, mismatch and fail_row hold their values until the next start.
- **abort**
  - Sampled high in SETTLE or SAMPLE: go to IDLE on the next edge with no done pulse.
  - In that cycle no SAMPLE capture occurs.
  - table_out keeps the rows already captured; dut_in holds its last value.
  - abort takes priority over the SAMPLE capture in the same cycle. It is ignored in IDLE and DONE.
- **start** while busy or in DONE is ignored; there is no queuing.
- **Reset** (rst_n low, at any time including mid-sweep): state=IDLE; dut_in, busy, done, table_out, mismatch and fail_row all 0; counter 0. A new start is required after reset.

## Timing
- Start is sampled at edge 0. With S = SETTLE_CYCLES and R = 2**N_IN:
  - Row r is driven from edge r(S+1)+1.
  - Row r is sampled at edge (r+1)(S+1).
  - done is high in the cycle after edge R(S+1)+1.
  - A new start is accepted in the cycle following done.
- Total sweep is R(S+1)+2 cycles, start to the first cycle a new start can be accepted.
- Defaults (N_IN=2, S=2): samples at edges 3, 6, 9, 12; done at edge 13.
- All outputs are registered. No combinational path exists from inputs to outputs.
- dut_c is sampled in SAMPLE only. The controlled unit must produce a valid dut_c within S cycles of a dut_in change.

## Structure
- Shared package `gate_sweep_pkg` holds:
  - state encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - the counter width constant (4 bits).
- One natural sub-module, `settle_counter`: a loadable down-counter with a zero flag and a load value of SETTLE_CYCLES-1.
- FSM, row counter and table/compare logic stay in the top module.

## Test plan
- **AND-gate unit, expected=4'b1000, defaults:** dut_in steps 0,1,2,3. Required: table_out=4'b1000, mismatch=0, fail_row=0, done pulse at edge 13, busy high for edges 1–12.
- **XOR-gate unit, expected=4'b1000:** Required: table_out=4'b0110, mismatch=1, fail_row=1 (row 3 also differs but is not reported), done still at edge 13.
- **start re-asserted at edges 4 and 13, expected=4'b1000:** Required: sweep unaffected, done only at edge 13, no second sweep. A start at edge 14 begins a new sweep and clears table_out.
- **abort high at edge 5:** Required: IDLE after edge 6, no done, table_out[0] captured and bits 3:1 =0, busy low.
- **rst_n low asynchronously mid-SETTLE of row 2:** Required: all outputs 0 immediately. After release, no activity until start.
- **SETTLE_CYCLES=1, XNOR unit, expected=4'b1001:** Required: samples at edges 2, 4, 6, 8; done at edge 9; table_out=4'b1001; mismatch=0.
